mux8_out_fifo: RTL and testbench
================================

# mux8_out_fifo

Synchronous 4-entry, 8-bit buffer that captures the output of the 8-bit 2:1 selector stage (`mux8sch`) and holds it for a slower downstream consumer. Each write pushes one byte from `MUX_OUT`. Each read pops one byte onto a registered output. Full/empty status, occupancy count and sticky error flags let the producer and consumer throttle without losing data.

## Interface
- `WIDTH`, 8, data width; matches `MUX_OUT`.
- `DEPTH`, 4, number of entries; must be a power of two, at least 2.
- `AW`, 2, pointer width, log2(`DEPTH`).

- `CLK` in 1 — sole clock; all state changes on the rising edge.
- `RST` in 1 — reset, synchronous, active-high.
- `WR_EN` in 1 — push request; samples `DIN` on the same edge.
- `DIN` in `WIDTH` — write data; driven from `mux8sch.MUX_OUT`.
- `RD_EN` in 1 — pop request.
- `DOUT` out `WIDTH` — registered read data.
- `FULL` out 1 — occupancy equals `DEPTH`.
- `EMPTY` out 1 — occupancy equals 0.
- `COUNT` out `AW+1` — current occupancy, 0..`DEPTH`.
- `OVERFLOW` out 1 — sticky; set when a write is rejected.
- `UNDERFLOW` out 1 — sticky; set when a read is rejected.

## Operation
- Storage is a `DEPTH`×`WIDTH` register array, with write pointer `wp` and read pointer `rp`, each `AW` bits wide.
  - Pointers wrap modulo `DEPTH`: `DEPTH-1` + 1 → 0.
  - A separate `COUNT` register is the occupancy source; `FULL` and `EMPTY` decode from `COUNT`.
- Write accepted when `WR_EN`=1 and (`FULL`=0, or `RD_EN`=1 at the same edge):
  - `mem[wp]` ← `DIN`
  - `wp` ← `wp`+1
- Read accepted when `RD_EN`=1 and `EMPTY`=0:
  - `DOUT` ← `mem[rp]`
  - `rp` ← `rp`+1
- `DOUT` holds its last value when no read is accepted.
- `COUNT` update per edge:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged on both or neither.
- Simultaneous cases:
  - Full, `WR_EN`=`RD_EN`=1: both accepted; the oldest byte is output, the new byte is stored in the freed slot, `COUNT` stays at `DEPTH`, `OVERFLOW` unchanged.
  - Empty, `WR_EN`=`RD_EN`=1: write accepted, read rejected; `COUNT` → 1, `UNDERFLOW` set, `DOUT` unchanged. There is no bypass/fall-through.
- Errors:
  - `WR_EN`=1 while `FULL`=1 and `RD_EN`=0: data dropped, array and `wp` unchanged, `OVERFLOW` ← 1.
  - `RD_EN`=1 while `EMPTY`=1: `UNDERFLOW` ← 1.
  - Both flags are cleared only by `RST`.
- Reset (`RST`=1 at an edge), including mid-stream:
  - `wp`=`rp`=0, `COUNT`=0, `EMPTY`=1, `FULL`=0, `DOUT`=0, `OVERFLOW`=`UNDERFLOW`=0.
  - Array contents are don't-care.
  - `RST` has priority over `WR_EN`/`RD_EN` on the same edge.

## Timing
- Write-to-status latency: 1 cycle. `COUNT`/`FULL`/`EMPTY` reflect a push after the edge that sampled it.
- Read latency: 1 cycle. `DOUT` is valid after the edge where `RD_EN`=1 was accepted.
- Write-to-read minimum: a byte written at edge N can be read at edge N+1 and appears on `DOUT` after N+1.
- Sustained throughput: one write plus one read per cycle at any occupancy 1..`DEPTH`.
- Outputs are all registered or decoded from registers only. There is no combinational path from `WR_EN`/`RD_EN`/`DIN` to any output.

## Test plan
- Reset then idle:
  - Required: `EMPTY`=1, `FULL`=0, `COUNT`=0, `DOUT`=8'h00, both flags 0.
- Fill and drain:
  - Stimulus: write 8'h5F, 8'hC8, 8'h91, 8'h1D on consecutive edges.
  - Required: `FULL`=1, `COUNT`=4.
  - Then four reads; required: `DOUT` = 5F, C8, 91, 1D in order, `EMPTY`=1 after the last.
- Overflow:
  - Stimulus: with FIFO full, write 8'hEA with `RD_EN`=0.
  - Required: `OVERFLOW`=1, `COUNT`=4; subsequent drain yields the original four bytes, not EA.
- Underflow and empty simultaneity:
  - Stimulus: from empty, assert `RD_EN`=1 alone.
  - Required: `UNDERFLOW`=1, `DOUT` unchanged.
  - Stimulus: then `WR_EN`=`RD_EN`=1 with `DIN`=8'h73.
  - Required: `COUNT`=1, `DOUT` unchanged; next read returns 73.
- Full simultaneity and wrap:
  - Stimulus: fill to 4, then do 6 cycles of `WR_EN`=`RD_EN`=1 with `DIN` = 74, A8, EA, 5F, C8, 91.
  - Required: `COUNT` stays 4, no `OVERFLOW`, `DOUT` follows FIFO order across pointer wrap.
- Reset mid-operation:
  - Stimulus: at `COUNT`=3 assert `RST` together with `WR_EN`=1.
  - Required: next cycle `COUNT`=0, `EMPTY`=1, `DOUT`=0, flags cleared, no byte stored.

Source files
------------

// File: rtl/mux8_out_fifo.sv
// rtl/mux8_out_fifo.sv - 4-entry byte buffer behind the mux8sch selector output
//
// Purpose: captures bytes from the 8-bit 2:1 selector stage and holds them for
// a slower consumer. Registered read data, occupancy count, full/empty status
// and sticky overflow/underflow flags.
//
// Ports:
//   CLK       in            clock, rising edge
//   RST       in            synchronous active-high reset
//   WR_EN     in            push request, DIN sampled on the same edge
//   DIN       in  [WIDTH]   write data
//   RD_EN     in            pop request
//   DOUT      out [WIDTH]   registered read data, holds when no pop
//   FULL      out           occupancy == DEPTH
//   EMPTY     out           occupancy == 0
//   COUNT     out [AW+1]    occupancy 0..DEPTH
//   OVERFLOW  out           sticky, a push was rejected
//   UNDERFLOW out           sticky, a pop was rejected
module mux8_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [AW:0]      COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  // Status decodes from the count register only, so no input reaches an output.
  assign FULL  = (count == CNT_MAX);
  assign EMPTY = (count == '0);
  assign COUNT = count;

  // A push into a full buffer is allowed when a pop frees a slot on the same edge.
  // A full buffer is never empty, so that pop is always accepted.
  always_comb begin
    wr_ok = WR_EN && (!FULL || RD_EN);
    rd_ok = RD_EN && !EMPTY;
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) begin
      mem[wp] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      DOUT      <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= wp + PTR_ONE;
      end
      if (rd_ok) begin
        DOUT <= mem[rp];
        rp   <= rp + PTR_ONE;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CNT_ONE;
      end else if (rd_ok && !wr_ok) begin
        count <= count - CNT_ONE;
      end
      if (WR_EN && !wr_ok) begin
        OVERFLOW <= 1'b1;
      end
      if (RD_EN && !rd_ok) begin
        UNDERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux8_out_fifo.sv
// tb/tb_mux8_out_fifo.sv - self-checking bench for mux8_out_fifo
module tb_mux8_out_fifo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       RD_EN = 1'b0;
  logic [7:0] DOUT;
  logic       FULL;
  logic       EMPTY;
  logic [2:0] COUNT;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic [7:0] exp_dout = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  mux8_out_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .DIN(DIN), .RD_EN(RD_EN),
    .DOUT(DOUT), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},  32'(DOUT),      32'(exp_dout));
    chk({tag, ".count"}, 32'(COUNT),     32'(sb.size()));
    chk({tag, ".full"},  32'(FULL),      32'(sb.size() == 4));
    chk({tag, ".empty"}, 32'(EMPTY),     32'(sb.size() == 0));
    chk({tag, ".ovf"},   32'(OVERFLOW),  32'(exp_ovf));
    chk({tag, ".unf"},   32'(UNDERFLOW), 32'(exp_unf));
  endtask

  // One clock: predict from the scoreboard, drive, step, compare.
  task automatic cyc(input string tag, input logic wr, input logic rd, input logic [7:0] d);
    bit mfull;
    bit mempty;
    mfull  = (sb.size() == 4);
    mempty = (sb.size() == 0);
    if (rd && !mempty) exp_dout = sb.pop_front();
    if (wr && (!mfull || rd)) sb.push_back(d);
    if (wr && mfull && !rd) exp_ovf = 1'b1;
    if (rd && mempty) exp_unf = 1'b1;
    WR_EN = wr;
    RD_EN = rd;
    DIN   = d;
    @(posedge CLK);
    #1;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    chk_all(tag);
  endtask

  task automatic do_reset(input logic wr, input logic [7:0] d);
    RST   = 1'b1;
    WR_EN = wr;
    DIN   = d;
    @(posedge CLK);
    #1;
    RST   = 1'b0;
    WR_EN = 1'b0;
    sb.delete();
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    chk_all("reset");
  endtask

  initial begin
    // Reset then idle
    do_reset(1'b0, 8'h00);
    cyc("idle", 1'b0, 1'b0, 8'h00);

    // Fill and drain with an overflow attempt while full
    cyc("fill0", 1'b1, 1'b0, 8'h5F);
    cyc("fill1", 1'b1, 1'b0, 8'hC8);
    cyc("fill2", 1'b1, 1'b0, 8'h91);
    cyc("fill3", 1'b1, 1'b0, 8'h1D);
    chk("full_after_fill", 32'(FULL), 32'd1);
    chk("count_after_fill", 32'(COUNT), 32'd4);
    cyc("ovf", 1'b1, 1'b0, 8'hEA);
    chk("ovf_set", 32'(OVERFLOW), 32'd1);
    cyc("drain0", 1'b0, 1'b1, 8'h00);
    chk("drain0_val", 32'(DOUT), 32'h5F);
    cyc("drain1", 1'b0, 1'b1, 8'h00);
    cyc("drain2", 1'b0, 1'b1, 8'h00);
    cyc("drain3", 1'b0, 1'b1, 8'h00);
    chk("drain3_val", 32'(DOUT), 32'h1D);
    chk("empty_after_drain", 32'(EMPTY), 32'd1);

    // Underflow, then simultaneous push/pop on empty
    cyc("unf", 1'b0, 1'b1, 8'h00);
    chk("unf_set", 32'(UNDERFLOW), 32'd1);
    chk("unf_dout_hold", 32'(DOUT), 32'h1D);
    cyc("empty_both", 1'b1, 1'b1, 8'h73);
    chk("empty_both_count", 32'(COUNT), 32'd1);
    chk("empty_both_dout", 32'(DOUT), 32'h1D);
    cyc("read73", 1'b0, 1'b1, 8'h00);
    chk("read73_val", 32'(DOUT), 32'h73);

    // Full simultaneity across pointer wrap, from clean flags
    do_reset(1'b0, 8'h00);
    cyc("wfill0", 1'b1, 1'b0, 8'h11);
    cyc("wfill1", 1'b1, 1'b0, 8'h22);
    cyc("wfill2", 1'b1, 1'b0, 8'h33);
    cyc("wfill3", 1'b1, 1'b0, 8'h44);
    cyc("both0", 1'b1, 1'b1, 8'h74);
    cyc("both1", 1'b1, 1'b1, 8'hA8);
    cyc("both2", 1'b1, 1'b1, 8'hEA);
    cyc("both3", 1'b1, 1'b1, 8'h5F);
    cyc("both4", 1'b1, 1'b1, 8'hC8);
    cyc("both5", 1'b1, 1'b1, 8'h91);
    chk("both_count", 32'(COUNT), 32'd4);
    chk("both_no_ovf", 32'(OVERFLOW), 32'd0);
    chk("both5_val", 32'(DOUT), 32'hA8);
    for (int i = 0; i < 4; i++) cyc("wdrain", 1'b0, 1'b1, 8'h00);
    chk("wdrain_last", 32'(DOUT), 32'h91);

    // Reset mid-operation with a simultaneous write
    cyc("pre0", 1'b1, 1'b0, 8'h01);
    cyc("pre1", 1'b1, 1'b0, 8'h02);
    cyc("pre2", 1'b1, 1'b0, 8'h03);
    chk("pre_count", 32'(COUNT), 32'd3);
    do_reset(1'b1, 8'hAA);
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    cyc("post_rst_read", 1'b0, 1'b1, 8'h00);
    cyc("post_w", 1'b1, 1'b0, 8'h5A);
    cyc("post_r", 1'b0, 1'b1, 8'h00);
    chk("post_r_val", 32'(DOUT), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
